// File: rtl/y_output_buffer_if.sv
// Result-buffer bus: four capture lanes in, one serialized word stream out.
// The master modport is the side that drives captures and the ready signal.
// The slave modport is the buffer itself.
interface y_output_buffer_if;
  logic        y_capture;
  logic [15:0] Y_in1;
  logic [15:0] Y_in2;
  logic [15:0] Y_in3;
  logic [15:0] Y_in4;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        busy;
  logic        unload_done;
  logic        cap_drop;

  modport master (
    output y_capture, Y_in1, Y_in2, Y_in3, Y_in4, out_ready,
    input  out_data, out_valid, busy, unload_done, cap_drop
  );

  modport slave (
    input  y_capture, Y_in1, Y_in2, Y_in3, Y_in4, out_ready,
    output out_data, out_valid, busy, unload_done, cap_drop
  );
endinterface

// File: rtl/y_output_buffer.sv
// Four-lane result buffer.
// FILL collects four captures per lane into 64-bit shift registers.
// DRAIN then serializes the sixteen words round-robin across the lanes,
// oldest capture first, under a valid/ready handshake.
module y_output_buffer (
  input  logic          clk,
  input  logic          rst,
  y_output_buffer_if.slave bus
);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cap_cnt, cap_cnt_nxt;
  logic [3:0]  out_cnt, out_cnt_nxt;
  logic [63:0] lane [4];
  logic [63:0] lane_nxt [4];
  logic        unload_nxt, drop_nxt;
  logic        unload_q, drop_q;
  logic [15:0] y_in [4];
  logic [1:0]  sel;

  assign y_in[0] = bus.Y_in1;
  assign y_in[1] = bus.Y_in2;
  assign y_in[2] = bus.Y_in3;
  assign y_in[3] = bus.Y_in4;

  // Words leave lane 1,2,3,4,1,... so the low counter bits pick the lane.
  assign sel = out_cnt[1:0];

  // State register, counters, lane storage and registered pulse outputs.
  // NOTE: the lane registers are real buffer state rather than a RAM, so they
  // are cleared by reset; words buffered before a reset must not reappear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      cap_cnt  <= 2'd0;
      out_cnt  <= 4'd0;
      unload_q <= 1'b0;
      drop_q   <= 1'b0;
      for (int i = 0; i < 4; i++) lane[i] <= 64'd0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // pre-edge values no matter the statement order.
      state    <= state_nxt;
      cap_cnt  <= cap_cnt_nxt;
      out_cnt  <= out_cnt_nxt;
      unload_q <= unload_nxt;
      drop_q   <= drop_nxt;
      for (int i = 0; i < 4; i++) lane[i] <= lane_nxt[i];
    end
  end

  // Next-state logic: capture in FILL, handshake-driven shift-out in DRAIN.
  always_comb begin
    // NOTE: everything gets a hold/idle default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    state_nxt   = state;
    cap_cnt_nxt = cap_cnt;
    out_cnt_nxt = out_cnt;
    unload_nxt  = 1'b0;
    drop_nxt    = 1'b0;
    for (int i = 0; i < 4; i++) lane_nxt[i] = lane[i];

    unique case (state)
      FILL: begin
        if (bus.y_capture) begin
          for (int i = 0; i < 4; i++) lane_nxt[i] = {lane[i][47:0], y_in[i]};
          cap_cnt_nxt = cap_cnt + 2'd1;
          if (cap_cnt == 2'd3) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // A capture arriving while draining is discarded and flagged.
        drop_nxt = bus.y_capture;
        if (bus.out_ready) begin
          lane_nxt[sel] = {lane[sel][47:0], 16'h0000};
          out_cnt_nxt   = out_cnt + 4'd1;
          if (out_cnt == 4'd15) begin
            state_nxt  = FILL;
            unload_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  assign bus.out_valid   = (state == DRAIN);
  assign bus.busy        = bus.out_valid;
  assign bus.out_data    = (state == DRAIN) ? lane[sel][63:48] : 16'h0000;
  assign bus.unload_done = unload_q;
  assign bus.cap_drop    = drop_q;

endmodule

// File: tb/tb_y_output_buffer.sv
// Scoreboard bench for y_output_buffer.
// The driver pushes the expected word order when it starts a fill.
// The monitor pops and compares on every accepted word.
module tb_y_output_buffer;

  logic clk;
  logic rst;
  y_output_buffer_if bus ();

  y_output_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q [$];
  logic [15:0] held;
  bit          holding = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected word for lane n, capture index c: 16'h(n)(c)(tag).
  function automatic logic [15:0] word(input int n, input int c, input logic [7:0] tag);
    logic [3:0] nn;
    logic [3:0] cc;
    nn = n[3:0];
    cc = c[3:0];
    return {nn, cc, tag};
  endfunction

  // Monitor: compare accepted words and check hold stability while stalled.
  always @(negedge clk) begin
    if (!rst) begin
      holding = 1'b0;
    end else if (bus.out_valid) begin
      if (holding) check("hold_stable", {16'h0, bus.out_data}, {16'h0, held});
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_word: got %h, expected no word (t=%0t)", bus.out_data, $time);
        end else begin
          check("out_word", {16'h0, bus.out_data}, {16'h0, exp_q.pop_front()});
        end
        holding = 1'b0;
      end else begin
        holding = 1'b1;
        held    = bus.out_data;
      end
    end else begin
      check("idle_data_zero", {16'h0, bus.out_data}, 32'h0);
      holding = 1'b0;
    end
  end

  // Apply ncap captures; with a full fill, queue the 16 expected words first.
  task automatic fill(input int ncap, input logic [7:0] tag);
    if (ncap == 4)
      for (int k = 0; k < 16; k++) exp_q.push_back(word(k % 4 + 1, k / 4, tag));
    for (int c = 0; c < ncap; c++) begin
      check("valid_low_in_fill", {31'h0, bus.out_valid}, 32'h0);
      bus.y_capture = 1'b1;
      bus.Y_in1 = word(1, c, tag);
      bus.Y_in2 = word(2, c, tag);
      bus.Y_in3 = word(3, c, tag);
      bus.Y_in4 = word(4, c, tag);
      @(posedge clk); #1;
      bus.y_capture = 1'b0;
    end
    if (ncap == 4) begin
      check("valid_after_fill", {31'h0, bus.out_valid}, 32'h1);
      check("busy_after_fill", {31'h0, bus.busy}, 32'h1);
    end
  endtask

  // Drain up to stop_after words. Mode 0 holds ready high; mode 1 uses 1,0,0.
  // drop_at injects a capture alongside that handshake.
  task automatic drain(input int mode, input int drop_at, input int stop_after);
    int hs = 0;
    int cyc = 0;
    bit prev_drop = 1'b0;
    bit this_drop;
    while (hs < stop_after) begin
      if (cyc >= 200 || !bus.out_valid) begin
        check("drain_progress", hs, stop_after);
        break;
      end
      bus.out_ready = (mode == 0) || (cyc % 3 == 0);
      this_drop = bus.out_ready && (hs == drop_at);
      bus.y_capture = this_drop;
      if (this_drop) begin
        bus.Y_in1 = 16'hDEAD; bus.Y_in2 = 16'hDEAD;
        bus.Y_in3 = 16'hDEAD; bus.Y_in4 = 16'hDEAD;
      end
      @(posedge clk); #1;
      bus.y_capture = 1'b0;
      if (bus.out_ready) hs++;
      if (this_drop) check("cap_drop_pulse", {31'h0, bus.cap_drop}, 32'h1);
      else if (prev_drop) check("cap_drop_one_cycle", {31'h0, bus.cap_drop}, 32'h0);
      if (hs < 16) check("no_early_unload", {31'h0, bus.unload_done}, 32'h0);
      prev_drop = this_drop;
      cyc++;
    end
    bus.out_ready = 1'b0;
    if (stop_after == 16) begin
      check("unload_pulse", {31'h0, bus.unload_done}, 32'h1);
      check("valid_low_after", {31'h0, bus.out_valid}, 32'h0);
      check("busy_low_after", {31'h0, bus.busy}, 32'h0);
      check("all_words_seen", exp_q.size(), 0);
      if (mode == 0) check("drain_cycles", cyc, 16);
      @(posedge clk); #1;
      check("unload_one_cycle", {31'h0, bus.unload_done}, 32'h0);
      check("cap_drop_clear", {31'h0, bus.cap_drop}, 32'h0);
    end
  endtask

  // Assert reset mid-cycle, check outputs clear at once, discard pending words.
  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_data", {16'h0, bus.out_data}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    exp_q.delete();
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    bus.y_capture = 1'b0;
    bus.out_ready = 1'b0;
    bus.Y_in1 = '0; bus.Y_in2 = '0; bus.Y_in3 = '0; bus.Y_in4 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {31'h0, bus.out_valid}, 32'h0);
    check("reset_busy", {31'h0, bus.busy}, 32'h0);
    check("reset_data", {16'h0, bus.out_data}, 32'h0);
    check("reset_unload", {31'h0, bus.unload_done}, 32'h0);
    check("reset_drop", {31'h0, bus.cap_drop}, 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Basic fill, ready held high.
    fill(4, 8'h00);
    drain(0, -1, 16);
    // Same fill, ready toggling 1,0,0.
    fill(4, 8'h00);
    drain(1, -1, 16);
    // Capture pulsed during drain.
    fill(4, 8'h11);
    drain(0, 5, 16);
    // Capture on the final handshake.
    fill(4, 8'h22);
    drain(0, 15, 16);
    // Reset after two captures; a fresh fill needs four captures.
    fill(2, 8'h33);
    pulse_reset();
    fill(4, 8'h44);
    drain(0, -1, 16);
    // Reset after seven drained words.
    fill(4, 8'h55);
    drain(0, -1, 7);
    pulse_reset();
    fill(4, 8'h66);
    drain(1, -1, 16);
    // Back-to-back rounds with distinct data.
    fill(4, 8'h77);
    drain(0, -1, 16);
    fill(4, 8'h88);
    drain(0, -1, 16);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
